// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and WIDTH legality.
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } div_state_t;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

   function automatic bit width_ok(input int w);
      return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-compare-subtract step on magnitudes; purely combinational.
module div_step
   import divider_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH:0]   rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH:0]   divisor,
   output logic [WIDTH:0]   rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] rem_sh;
   // The partial remainder is always below the divisor, so its MSB is zero here.
   logic           unused_rem_msb;

   assign unused_rem_msb = rem[WIDTH];

   always_comb begin
      rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
      if (rem_sh >= divisor) begin
         rem_next = rem_sh - divisor;
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_next = rem_sh;
         quo_next = {quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/param_divider.sv
// Multi-cycle signed/unsigned restoring divider: WIDTH iterations on magnitudes,
// then a sign fix-up; divide-by-zero bypasses the iteration.
module param_divider
   import divider_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             div_by_zero,
   output logic             overflow
);

   localparam int               CNT_W   = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   if (!width_ok(WIDTH)) begin : g_width_chk
      $error("param_divider: WIDTH must be within 2..32");
   end

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
      return (s && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
   endfunction

   div_state_t       state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
   logic             sgn_q, sgn_d;
   logic [WIDTH:0]   rem_q, rem_d, div_q, div_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             zpend_q, zpend_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             dz_q, dz_d, ov_q, ov_d;

   logic [WIDTH:0]   step_rem;
   logic [WIDTH-1:0] step_quo;
   logic             neg_quo, neg_rem;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (div_q),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   assign neg_quo = sgn_q & (x_q[WIDTH-1] ^ y_q[WIDTH-1]);
   assign neg_rem = sgn_q & x_q[WIDTH-1];

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      sgn_d   = sgn_q;
      rem_d   = rem_q;
      div_d   = div_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      zpend_d = zpend_q;
      done_d  = 1'b0;
      a_d     = a_q;
      b_d     = b_q;
      dz_d    = dz_q;
      ov_d    = ov_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               x_d   = x;
               y_d   = y;
               sgn_d = is_signed;
               rem_d = '0;
               quo_d = mag(x, is_signed);
               div_d = {1'b0, mag(y, is_signed)};
               cnt_d = '0;
               if (y == '0) begin
                  state_d = DONE;
                  zpend_d = 1'b1;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIXUP;
         end
         FIXUP: begin
            a_d     = neg_quo ? (~quo_q + WIDTH'(1)) : quo_q;
            b_d     = neg_rem ? (~rem_q[WIDTH-1:0] + WIDTH'(1)) : rem_q[WIDTH-1:0];
            dz_d    = 1'b0;
            ov_d    = sgn_q && (x_q == MIN_VAL) && (y_q == '1);
            done_d  = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            // A zero divisor enters DONE unpublished; it publishes here and stays one more cycle.
            if (zpend_q) begin
               a_d     = '1;
               b_d     = x_q;
               dz_d    = 1'b1;
               ov_d    = 1'b0;
               done_d  = 1'b1;
               zpend_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         sgn_q   <= 1'b0;
         rem_q   <= '0;
         div_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         zpend_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         dz_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         sgn_q   <= sgn_d;
         rem_q   <= rem_d;
         div_q   <= div_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         zpend_q <= zpend_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         a_q     <= a_d;
         b_q     <= b_d;
         dz_q    <= dz_d;
         ov_q    <= ov_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign a           = a_q;
   assign b           = b_q;
   assign div_by_zero = dz_q;
   assign overflow    = ov_q;

endmodule

// File: tb/tb_param_divider.sv
// Directed bench for param_divider at WIDTH=16, plus a boundary-value sweep at WIDTH=8.
module tb_param_divider;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [15:0] x = '0;
   logic [15:0] y = '0;
   logic        busy, done, dz, ov;
   logic [15:0] a, b;

   logic        start8 = 1'b0;
   logic        sg8 = 1'b0;
   logic [7:0]  x8 = '0;
   logic [7:0]  y8 = '0;
   logic        busy8, done8, dz8, ov8;
   logic [7:0]  a8, b8;

   int total = 0;
   int bad = 0;

   logic [7:0] vals [8] = '{8'h00, 8'h01, 8'h02, 8'h07, 8'h7F, 8'h80, 8'h81, 8'hFF};

   always #5 clk = ~clk;

   param_divider #(.WIDTH(16)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .is_signed(is_signed),
      .x(x), .y(y), .busy(busy), .done(done), .a(a), .b(b),
      .div_by_zero(dz), .overflow(ov)
   );

   param_divider #(.WIDTH(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .start(start8), .is_signed(sg8),
      .x(x8), .y(y8), .busy(busy8), .done(done8), .a(a8), .b(b8),
      .div_by_zero(dz8), .overflow(ov8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run16(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                        input logic sv, input logic [15:0] ea, input logic [15:0] eb,
                        input logic edz, input logic eov, input int elat);
      int n;
      @(negedge clk);
      x = xv; y = yv; is_signed = sv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, ".busy_edge0"}, busy, 1);
      wait_done(n);
      chk({tag, ".latency"}, n, elat);
      chk({tag, ".busy_done"}, busy, 1);
      chk({tag, ".a"}, a, ea);
      chk({tag, ".b"}, b, eb);
      chk({tag, ".div_by_zero"}, dz, edz);
      chk({tag, ".overflow"}, ov, eov);
      @(negedge clk);
      chk({tag, ".done_drop"}, done, 0);
      chk({tag, ".busy_drop"}, busy, 0);
   endtask

   function automatic void model8(input logic [7:0] xv, input logic [7:0] yv, input logic sv,
                                  output logic [7:0] ea, output logic [7:0] eb,
                                  output logic edz, output logic eov);
      int ux, uy, sx, sy;
      ux = xv; uy = yv;
      sx = $signed(xv); sy = $signed(yv);
      edz = 1'b0; eov = 1'b0;
      if (yv == 8'h00) begin
         ea = 8'hFF; eb = xv; edz = 1'b1;
      end else if (!sv) begin
         ea = 8'(ux / uy); eb = 8'(ux % uy);
      end else begin
         ea = 8'(sx / sy); eb = 8'(sx % sy);
         eov = (xv == 8'h80) && (yv == 8'hFF);
      end
   endfunction

   task automatic run8(input logic [7:0] xv, input logic [7:0] yv, input logic sv);
      logic [7:0] ea, eb;
      logic       edz, eov;
      int         n, elat;
      string      tag;
      model8(xv, yv, sv, ea, eb, edz, eov);
      elat = (yv == 8'h00) ? 1 : 9;
      tag = $sformatf("w8 s=%0d %0h/%0h", sv, xv, yv);
      @(negedge clk);
      x8 = xv; y8 = yv; sg8 = sv; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      n = 0;
      while (done8 !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " latency"}, n, elat);
      chk({tag, " a"}, a8, ea);
      chk({tag, " b"}, b8, eb);
      chk({tag, " dz"}, dz8, edz);
      chk({tag, " ov"}, ov8, eov);
      @(negedge clk);
   endtask

   initial begin
      int n, m;
      #3 reset_n = 1'b0;
      @(negedge clk);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.a", a, 0);
      chk("rst.b", b, 0);
      chk("rst.dz", dz, 0);
      chk("rst.ov", ov, 0);
      chk("rst.w8_a", a8, 0);
      reset_n = 1'b1;

      run16("u100/7",   16'd100,  16'd7,    1'b0, 16'd14,   16'd2,    1'b0, 1'b0, 17);
      run16("s-100/7",  16'hFF9C, 16'd7,    1'b1, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 17);
      run16("s100/-7",  16'h0064, 16'hFFF9, 1'b1, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 17);
      run16("s-7/-2",   16'hFFF9, 16'hFFFE, 1'b1, 16'h0003, 16'hFFFF, 1'b0, 1'b0, 17);
      run16("s_min/-1", 16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1, 17);
      run16("u_8000/ffff", 16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0, 17);
      run16("u_ffff/1", 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17);
      run16("s_min/-1b", 16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1, 17);
      run16("u_dz",     16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1);
      run16("s_dz",     16'h1234, 16'h0000, 1'b1, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 1);
      run16("u65535/16", 16'hFFFF, 16'd16,  1'b0, 16'h0FFF, 16'h000F, 1'b0, 1'b0, 17);

      repeat (3) @(negedge clk);
      chk("hold.a", a, 16'h0FFF);
      chk("hold.b", b, 16'h000F);

      // Second start during CALC must not disturb the running 50/3.
      @(negedge clk);
      x = 16'd50; y = 16'd3; is_signed = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      x = 16'd7; y = 16'd2; is_signed = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(n);
      chk("ign.latency", n, 12);
      chk("ign.a", a, 16'd16);
      chk("ign.b", b, 16'd2);
      @(negedge clk);

      // Start held high: the second acceptance follows the first by WIDTH+3 edges.
      @(negedge clk);
      x = 16'd100; y = 16'd7; is_signed = 1'b0; start = 1'b1;
      @(negedge clk);
      wait_done(n);
      chk("b2b.latency1", n, 17);
      m = 0;
      do begin
         @(negedge clk);
         m++;
      end while (done !== 1'b1 && m < 100);
      start = 1'b0;
      chk("b2b.spacing", m, 19);
      chk("b2b.a", a, 16'd14);
      chk("b2b.b", b, 16'd2);
      @(negedge clk);
      chk("b2b.idle1", busy, 0);
      @(negedge clk);
      chk("b2b.idle2", busy, 0);

      // Asynchronous reset mid-CALC aborts without a done pulse.
      x = 16'd100; y = 16'd7; is_signed = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("abort.busy", busy, 0);
      chk("abort.done", done, 0);
      chk("abort.a", a, 0);
      chk("abort.b", b, 0);
      chk("abort.dz", dz, 0);
      chk("abort.ov", ov, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort.no_done", done, 0);
      end
      reset_n = 1'b1;
      run16("post_rst9/4", 16'd9, 16'd4, 1'b0, 16'd2, 16'd1, 1'b0, 1'b0, 17);

      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            run8(vals[i], vals[j], 1'b0);
            run8(vals[i], vals[j], 1'b1);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
